// File: rtl/div_arbiter_if.sv
// Shared-divider arbiter bus: two requesters, divider handshake, response.
// master = requester/divider side, slave = arbiter side.
interface div_arbiter_if #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32
);
    logic [1:0]                req_valid;
    logic [1:0]                req_ready;
    logic [DIVIDEND_WIDTH-1:0] req_dividend0;
    logic [DIVIDEND_WIDTH-1:0] req_dividend1;
    logic [DIVISOR_WIDTH-1:0]  req_divisor0;
    logic [DIVISOR_WIDTH-1:0]  req_divisor1;

    logic                      div_valid_in;
    logic [DIVIDEND_WIDTH-1:0] div_dividend;
    logic [DIVISOR_WIDTH-1:0]  div_divisor;
    logic [DIVIDEND_WIDTH-1:0] div_quotient;
    logic [DIVISOR_WIDTH-1:0]  div_remainder;
    logic                      div_overflow;
    logic                      div_valid_out;

    logic [1:0]                rsp_valid;
    logic [DIVIDEND_WIDTH-1:0] rsp_quotient;
    logic [DIVISOR_WIDTH-1:0]  rsp_remainder;
    logic                      rsp_overflow;
    logic                      rsp_timeout;

    modport master (
        output req_valid, req_dividend0, req_dividend1,
        output req_divisor0, req_divisor1,
        output div_quotient, div_remainder,
        output div_overflow, div_valid_out,
        input  req_ready,
        input  div_valid_in, div_dividend, div_divisor,
        input  rsp_valid, rsp_quotient, rsp_remainder,
        input  rsp_overflow, rsp_timeout
    );

    modport slave (
        input  req_valid, req_dividend0, req_dividend1,
        input  req_divisor0, req_divisor1,
        input  div_quotient, div_remainder,
        input  div_overflow, div_valid_out,
        output req_ready,
        output div_valid_in, div_dividend, div_divisor,
        output rsp_valid, rsp_quotient, rsp_remainder,
        output rsp_overflow, rsp_timeout
    );
endinterface

// File: rtl/div_arbiter.sv
// Round-robin arbiter sharing one divider between two requesters.
// Ports: clk, reset (async, active-high), bus (div_arbiter_if.slave).
module div_arbiter #(
    parameter int DIVIDEND_WIDTH = 64,
    parameter int DIVISOR_WIDTH  = 32,
    parameter int TIMEOUT_CYCLES = 80
) (
    input  logic         clk,
    input  logic         reset,
    div_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESPOND
    } state_t;

    localparam logic [7:0] LP_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t                    r_state;
    logic                      r_last;
    logic                      r_owner;
    logic [DIVIDEND_WIDTH-1:0] r_dividend;
    logic [DIVISOR_WIDTH-1:0]  r_divisor;
    logic [7:0]                r_count;
    logic                      r_div_valid_in;
    logic [1:0]                r_rsp_valid;
    logic [DIVIDEND_WIDTH-1:0] r_rsp_quotient;
    logic [DIVISOR_WIDTH-1:0]  r_rsp_remainder;
    logic                      r_rsp_overflow;
    logic                      r_rsp_timeout;

    logic                      w_grant;
    logic [1:0]                w_ready;
    logic                      w_accept;
    logic [DIVIDEND_WIDTH-1:0] w_dividend;
    logic [DIVISOR_WIDTH-1:0]  w_divisor;
    logic [1:0]                w_owner_oh;

    // On a tie the requester not served last wins.
    always_comb begin
        w_grant = bus.req_valid[1];
        if (&bus.req_valid) begin
            w_grant = ~r_last;
        end
        w_ready = 2'b00;
        if (r_state == IDLE && |bus.req_valid) begin
            w_ready = w_grant ? 2'b10 : 2'b01;
        end
        w_accept   = |(bus.req_valid & w_ready);
        w_dividend = w_grant ? bus.req_dividend1
                             : bus.req_dividend0;
        w_divisor  = w_grant ? bus.req_divisor1
                             : bus.req_divisor0;
        w_owner_oh = r_owner ? 2'b10 : 2'b01;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state         <= IDLE;
            r_last          <= 1'b1;
            r_owner         <= 1'b0;
            r_dividend      <= '0;
            r_divisor       <= '0;
            r_count         <= '0;
            r_div_valid_in  <= 1'b0;
            r_rsp_valid     <= 2'b00;
            r_rsp_quotient  <= '0;
            r_rsp_remainder <= '0;
            r_rsp_overflow  <= 1'b0;
            r_rsp_timeout   <= 1'b0;
        end else begin
            r_div_valid_in <= 1'b0;
            r_rsp_valid    <= 2'b00;
            unique case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_owner    <= w_grant;
                        r_last     <= w_grant;
                        r_dividend <= w_dividend;
                        r_divisor  <= w_divisor;
                        // Zero divisor never reaches the divider.
                        if (w_divisor == '0) begin
                            r_rsp_valid     <= w_ready;
                            r_rsp_quotient  <= '1;
                            r_rsp_remainder <= '0;
                            r_rsp_overflow  <= 1'b1;
                            r_rsp_timeout   <= 1'b0;
                            r_state         <= RESPOND;
                        end else begin
                            r_div_valid_in <= 1'b1;
                            r_state        <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    r_count <= '0;
                    r_state <= WAIT;
                end
                WAIT: begin
                    r_count <= r_count + 8'd1;
                    // A result on the final cycle beats the timeout.
                    if (bus.div_valid_out) begin
                        r_rsp_valid     <= w_owner_oh;
                        r_rsp_quotient  <= bus.div_quotient;
                        r_rsp_remainder <= bus.div_remainder;
                        r_rsp_overflow  <= bus.div_overflow;
                        r_rsp_timeout   <= 1'b0;
                        r_state         <= RESPOND;
                    end else if (r_count == LP_LAST) begin
                        r_rsp_valid     <= w_owner_oh;
                        r_rsp_quotient  <= '0;
                        r_rsp_remainder <= '0;
                        r_rsp_overflow  <= 1'b1;
                        r_rsp_timeout   <= 1'b1;
                        r_state         <= RESPOND;
                    end
                end
                RESPOND: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = w_ready;
    assign bus.div_valid_in  = r_div_valid_in;
    assign bus.div_dividend  = r_dividend;
    assign bus.div_divisor   = r_divisor;
    assign bus.rsp_valid     = r_rsp_valid;
    assign bus.rsp_quotient  = r_rsp_quotient;
    assign bus.rsp_remainder = r_rsp_remainder;
    assign bus.rsp_overflow  = r_rsp_overflow;
    assign bus.rsp_timeout   = r_rsp_timeout;
endmodule

// File: tb/tb_div_arbiter.sv
// Bench for div_arbiter: directed scenarios then random traffic
// against a cycle-level transaction model and a behavioural divider.
module tb_div_arbiter;
    localparam int DW = 64;
    localparam int VW = 32;
    localparam int T  = 80;

    logic clk;
    logic reset;

    div_arbiter_if #(.DIVIDEND_WIDTH(DW), .DIVISOR_WIDTH(VW)) bus();

    div_arbiter #(
        .DIVIDEND_WIDTH(DW),
        .DIVISOR_WIDTH(VW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference signed divide (truncating, as a hardware divider does).
    task automatic ref_div(input logic [63:0] a, input logic [31:0] b,
                           output logic [63:0] q, output logic [31:0] r,
                           output logic o);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic signed [63:0] sr;
        sa = a;
        sb = {{32{b[31]}}, b};
        o  = (a == 64'h8000_0000_0000_0000) && (sb == -64'sd1);
        if (o) begin
            q = a;
            r = 32'd0;
        end else begin
            q  = sa / sb;
            sr = sa % sb;
            r  = sr[31:0];
        end
    endtask

    // Behavioural divider: answers L cycles after the start pulse,
    // L == 0 means it never answers.
    int          L = 1;
    logic        stray = 1'b0;
    int          m_cnt = 0;
    logic [63:0] m_q = '0;
    logic [31:0] m_r = '0;
    logic        m_o = 1'b0;

    always @(posedge clk) begin
        logic [63:0] q;
        logic [31:0] r;
        logic        o;
        if (bus.div_valid_in) begin
            ref_div(bus.div_dividend, bus.div_divisor, q, r, o);
            m_q   <= q;
            m_r   <= r;
            m_o   <= o;
            m_cnt <= L;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
        end
    end

    assign bus.div_valid_out = (m_cnt == 1) | stray;
    assign bus.div_quotient  = m_q;
    assign bus.div_remainder = m_r;
    assign bus.div_overflow  = m_o;

    // Stimulus values and transaction-level model state.
    logic [1:0]  v = 2'b00;
    logic [63:0] a0 = '0, a1 = '0;
    logic [31:0] b0 = '0, b1 = '0;
    int          cyc = 0;
    int          issue_c = -100;
    int          rsp_c = -1;
    int          last = 1;
    int          own = 0;
    int          served[$];
    logic [63:0] op_a, p_q, e_q;
    logic [31:0] op_b, p_r, e_r;
    logic        p_o, p_t, e_o, e_t;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic accept(input int g);
        own  = g;
        last = g;
        served.push_back(g);
        op_a = g ? a1 : a0;
        op_b = g ? b1 : b0;
        if (op_b == 32'd0) begin
            issue_c = -100;
            rsp_c   = cyc + 1;
            p_q = '1; p_r = '0; p_o = 1'b1; p_t = 1'b0;
        end else begin
            issue_c = cyc + 1;
            if (L == 0 || L > T) begin
                rsp_c = cyc + 2 + T;
                p_q = '0; p_r = '0; p_o = 1'b1; p_t = 1'b1;
            end else begin
                rsp_c = cyc + 2 + L;
                ref_div(op_a, op_b, p_q, p_r, p_o);
                p_t = 1'b0;
            end
        end
    endtask

    // One clock: drive requests, then check every output vs the model.
    task automatic tick();
        int         g;
        logic [1:0] er;
        logic [1:0] ev;
        @(posedge clk);
        #1;
        cyc++;
        bus.req_valid     = v;
        bus.req_dividend0 = a0;
        bus.req_dividend1 = a1;
        bus.req_divisor0  = b0;
        bus.req_divisor1  = b1;
        #1;
        g = -1;
        if (cyc > rsp_c && v != 2'b00) begin
            if (v == 2'b11) g = (last == 1) ? 0 : 1;
            else g = v[1] ? 1 : 0;
        end
        er = (g < 0) ? 2'b00 : ((g == 1) ? 2'b10 : 2'b01);
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("div_valid_in", 64'(bus.div_valid_in),
            64'(cyc == issue_c));
        if (cyc == issue_c) begin
            chk("div_dividend", bus.div_dividend, op_a);
            chk("div_divisor", 64'(bus.div_divisor), 64'(op_b));
        end
        if (cyc == rsp_c) begin
            e_q = p_q; e_r = p_r; e_o = p_o; e_t = p_t;
        end
        ev = (cyc != rsp_c) ? 2'b00 : ((own == 1) ? 2'b10 : 2'b01);
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(ev));
        chk("rsp_quotient", bus.rsp_quotient, e_q);
        chk("rsp_remainder", 64'(bus.rsp_remainder), 64'(e_r));
        chk("rsp_overflow", 64'(bus.rsp_overflow), 64'(e_o));
        chk("rsp_timeout", 64'(bus.rsp_timeout), 64'(e_t));
        if (g >= 0) accept(g);
    endtask

    task automatic run_idle();
        for (int k = 0; k < 300 && cyc <= rsp_c; k++) tick();
        chk("idle_bound", 64'(cyc > rsp_c), 64'd1);
    endtask

    // Asynchronous reset mid-cycle; outputs must clear at once.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_div_valid_in", 64'(bus.div_valid_in), 64'd0);
        chk("rst_div_dividend", bus.div_dividend, 64'd0);
        chk("rst_div_divisor", 64'(bus.div_divisor), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_quotient", bus.rsp_quotient, 64'd0);
        chk("rst_rsp_remainder", 64'(bus.rsp_remainder), 64'd0);
        chk("rst_rsp_overflow", 64'(bus.rsp_overflow), 64'd0);
        chk("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
        rsp_c = -1; issue_c = -100; last = 1;
        e_q = '0; e_r = '0; e_o = 1'b0; e_t = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    initial begin
        int n0;
        reset = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_dividend0 = '0; bus.req_dividend1 = '0;
        bus.req_divisor0  = '0; bus.req_divisor1  = '0;
        do_reset();

        // Single request 100/7, ten-cycle divider.
        L = 10; a0 = 64'd100; b0 = 32'd7; v = 2'b01;
        tick();
        v = 2'b00;
        run_idle();
        chk("r028_quot", bus.rsp_quotient, 64'd14);
        chk("r028_rem", 64'(bus.rsp_remainder), 64'd2);
        chk("r028_ovf", 64'(bus.rsp_overflow), 64'd0);
        chk("r028_tmo", 64'(bus.rsp_timeout), 64'd0);

        // Requester 1 divides by zero.
        a1 = 64'd5; b1 = 32'd0; v = 2'b10;
        tick();
        v = 2'b00;
        run_idle();
        chk("r030_quot", bus.rsp_quotient, '1);
        chk("r030_ovf", 64'(bus.rsp_overflow), 64'd1);

        // Both held: strict alternation starting with requester 0.
        L = 3;
        a0 = 64'd1000; b0 = 32'd9;
        a1 = -64'sd77; b1 = 32'd4;
        last = last;
        n0 = served.size();
        v = 2'b11;
        for (int k = 0; k < 200 && served.size() < n0 + 4; k++)
            tick();
        v = 2'b00;
        run_idle();
        for (int i = 0; i < 4; i++)
            chk("r029_order", 64'(served[n0 + i]), 64'(i % 2));

        // Divider never answers, then a stray result while idle.
        L = 0; a0 = 64'd50; b0 = 32'd3; v = 2'b01;
        tick();
        v = 2'b00;
        run_idle();
        chk("r031_tmo", 64'(bus.rsp_timeout), 64'd1);
        chk("r031_ovf", 64'(bus.rsp_overflow), 64'd1);
        stray = 1'b1;
        tick();
        stray = 1'b0;
        repeat (3) tick();

        // Result on the exact timeout cycle wins.
        L = T; a1 = 64'd81; b1 = 32'd9; v = 2'b10;
        tick();
        v = 2'b00;
        run_idle();
        chk("r032_tmo", 64'(bus.rsp_timeout), 64'd0);
        chk("r032_quot", bus.rsp_quotient, 64'd9);

        // Reset in WAIT; late divider answer must be ignored.
        L = 30; a0 = 64'd60; b0 = 32'd5; v = 2'b01;
        tick();
        v = 2'b00;
        repeat (5) tick();
        do_reset();
        repeat (40) tick();
        L = 4; v = 2'b11;
        tick();
        v = 2'b00;
        chk("r033_rr", 64'(served[$]), 64'd0);
        run_idle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            if (cyc + 1 > rsp_c)
                L = ($urandom_range(0, 39) == 0) ? 0
                    : int'($urandom_range(1, 12));
            v  = 2'($urandom_range(0, 3));
            a0 = {$urandom, $urandom};
            a1 = {$urandom, $urandom};
            b0 = $urandom_range(0, 7) == 0 ? 32'd0 :
                 ($urandom_range(0, 1) == 1 ? 32'($urandom)
                  : -32'($urandom_range(1, 50)));
            b1 = $urandom_range(0, 7) == 0 ? 32'd0 :
                 ($urandom_range(0, 1) == 1 ? 32'($urandom)
                  : -32'($urandom_range(1, 50)));
            tick();
        end
        v = 2'b00;
        run_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
